// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the 8N1 UART transmitter
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_BITS            = 8;
  localparam int BIT_IDX_W            = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with one-cycle tick on the last clock of each bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Held at zero while cleared so the first bit after acceptance gets a full period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_unit.sv
// rtl/uart_tx_unit.sv - byte-wide 8N1 UART transmitter with ready/enable handshake
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 tx
);

  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 rdy_q, rdy_d;
  logic                 baud_clr;
  logic                 bit_tick;

  assign baud_clr = (state_q == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .tick(bit_tick)
  );

  // The shift register moves right so the next data bit is always shift_q[1].
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    rdy_d     = rdy_q;
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        rdy_d = 1'b1;
        if (en) begin
          shift_d   = data;
          bit_idx_d = '0;
          state_d   = START;
          tx_d      = 1'b0;
          rdy_d     = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == LAST_IDX) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_tick) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      rdy_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      rdy_q     <= rdy_d;
    end
  end

  assign tx  = tx_q;
  assign rdy = rdy_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// tb/tb_uart_tx_unit.sv - scoreboard bench for uart_tx_unit at 16 clocks per bit
module tb_uart_tx_unit;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  typedef struct {
    logic [7:0] b;
    bit         ok;
  } frame_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] data;
  logic       rdy;
  logic       tx;

  int         n_cmp;
  int         n_fail;
  int         cyc;
  logic [7:0] exp_q[$];
  frame_t     obs_q[$];

  uart_tx_unit #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .data(data),
    .rdy (rdy),
    .tx  (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Line decoder: one sample per clock on the falling edge, frame aligned to the start bit.
  initial begin
    bit         m_active;
    int         m_s;
    int         bit_n;
    bit         m_ok;
    logic [7:0] m_byte;
    m_active = 0;
    m_s      = 0;
    m_ok     = 1;
    m_byte   = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        m_active = 0;
      end else begin
        if (!m_active && tx === 1'b0) begin
          m_active = 1;
          m_s      = 0;
          m_ok     = 1;
          m_byte   = '0;
        end
        if (m_active) begin
          bit_n = m_s / CPB;
          if (bit_n == 0) begin
            if (tx !== 1'b0) m_ok = 0;
          end else if (bit_n == 9) begin
            if (tx !== 1'b1) m_ok = 0;
          end else if (m_s % CPB == 0) begin
            m_byte[bit_n-1] = tx;
          end else if (tx !== m_byte[bit_n-1]) begin
            m_ok = 0;
          end
          if (m_s == FRAME - 1) begin
            obs_q.push_back('{m_byte, m_ok});
            m_active = 0;
          end else begin
            m_s++;
          end
        end
      end
    end
  end

  task automatic accept_byte(input logic [7:0] b, input bit push, output bit ok, output int acc);
    ok  = 0;
    acc = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (rdy === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      data = b;
      en   = 1'b1;
      if (push) exp_q.push_back(b);
      @(negedge clk);
      acc = cyc;
      en  = 1'b0;
    end
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 40 * FRAME; i++) begin
      if (obs_q.size() >= n) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst  = 1'b1;
    en   = 1'b0;
    data = '0;
    #2 rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || rdy !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_hold: %0d cycles with tx/rdy not 1, required 0", bad);
    end
    rst = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || rdy !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: %0d cycles with tx/rdy not 1, required 0", bad);
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] frame_bits;
    int         bad_bit[10];
    int         busy;
    bit         ok;
    frame_t     f;
    logic [7:0] e;
    frame_bits = {1'b1, 8'h41, 1'b0};
    for (int k = 0; k < 10; k++) bad_bit[k] = 0;
    busy = 0;
    data = 8'h41;
    en   = 1'b1;
    exp_q.push_back(8'h41);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (tx !== frame_bits[i/CPB]) bad_bit[i/CPB]++;
      if (rdy === 1'b0) busy++;
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (bad_bit[k] != 0) begin
        n_fail++;
        $display("FAIL single_bit%0d: %0d of 16 samples wrong, required level %0b", k, bad_bit[k], frame_bits[k]);
      end
    end
    n_cmp++;
    if (busy != FRAME) begin
      n_fail++;
      $display("FAIL single_busy_len: rdy low %0d cycles, required %0d", busy, FRAME);
    end
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_rdy_return: rdy=%0b, required 1", rdy);
    end
    wait_obs(1, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_frame_timeout: no frame decoded, required 1");
    end else begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      if (f.b !== e || !f.ok) begin
        n_fail++;
        $display("FAIL single_decode: got 0x%02h ok=%0b, required 0x%02h ok=1", f.b, f.ok, e);
      end
    end
  endtask

  task automatic test_en_held();
    bit         ok;
    int         acc;
    int         bad;
    frame_t     f;
    logic [7:0] e;
    data = 8'h41;
    en   = 1'b1;
    exp_q.push_back(8'h41);
    @(negedge clk);
    data = 8'h42;
    @(negedge clk);
    en = 1'b0;
    wait_obs(1, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL held_frame_timeout: no frame decoded, required 1");
    end else begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      if (f.b !== e || !f.ok) begin
        n_fail++;
        $display("FAIL held_decode: got 0x%02h ok=%0b, required 0x%02h ok=1", f.b, f.ok, e);
      end
    end
    bad = 0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (tx !== 1'b1 || rdy !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL held_no_second: %0d busy cycles, %0d extra frames, required 0 and 0", bad, obs_q.size());
    end
    accept_byte(8'h42, 1, ok, acc);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL held_accept_timeout: rdy never 1, required 1");
    end
    wait_obs(1, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL held_second_timeout: no frame decoded, required 1");
    end else begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      if (f.b !== e || !f.ok) begin
        n_fail++;
        $display("FAIL held_second_decode: got 0x%02h ok=%0b, required 0x%02h ok=1", f.b, f.ok, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int NF = 25;
    logic [7:0] b;
    logic [7:0] want;
    int         acc[NF];
    int         gap_bad;
    int         bad;
    bit         ok;
    bit         all_ok;
    frame_t     f;
    logic [7:0] e;
    b      = 8'h41;
    all_ok = 1;
    for (int i = 0; i < NF; i++) begin
      accept_byte(b, 1, ok, acc[i]);
      if (!ok) all_ok = 0;
      b = (b == 8'h57) ? 8'h41 : b + 8'h01;
    end
    n_cmp++;
    if (!all_ok) begin
      n_fail++;
      $display("FAIL b2b_accept_timeout: a byte was never accepted, required all %0d", NF);
    end
    gap_bad = 0;
    for (int i = 1; i < NF; i++) begin
      if (acc[i] - acc[i-1] != FRAME + 1) gap_bad++;
    end
    n_cmp++;
    if (gap_bad != 0) begin
      n_fail++;
      $display("FAIL b2b_spacing: %0d frames not %0d cycles apart, required 0", gap_bad, FRAME + 1);
    end
    wait_obs(NF, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_frames_timeout: %0d frames decoded, required %0d", obs_q.size(), NF);
    end else begin
      bad  = 0;
      want = 8'h41;
      for (int i = 0; i < NF; i++) begin
        f = obs_q.pop_front();
        e = exp_q.pop_front();
        if (f.b !== e || f.b !== want || !f.ok) bad++;
        want = (want == 8'h57) ? 8'h41 : want + 8'h01;
      end
      if (bad != 0) begin
        n_fail++;
        $display("FAIL b2b_stream: %0d corrupt or non-consecutive frames, required 0", bad);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit         ok;
    int         acc;
    frame_t     f;
    logic [7:0] e;
    accept_byte(8'hA5, 0, ok, acc);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midrst_accept_timeout: rdy never 1, required 1");
    end
    repeat (4 * CPB + 4) @(negedge clk);
    n_cmp++;
    if (tx !== 1'b0 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_bit3_level: tx=%0b rdy=%0b, required tx=0 rdy=0", tx, rdy);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (tx !== 1'b1 || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_async: tx=%0b rdy=%0b, required tx=1 rdy=1", tx, rdy);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0 || tx !== 1'b1 || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_abort: %0d frames, tx=%0b rdy=%0b, required 0 frames tx=1 rdy=1", obs_q.size(), tx, rdy);
    end
    accept_byte(8'h3C, 1, ok, acc);
    wait_obs(1, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midrst_next_timeout: no frame decoded, required 1");
    end else begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      if (f.b !== e || !f.ok) begin
        n_fail++;
        $display("FAIL midrst_next_decode: got 0x%02h ok=%0b, required 0x%02h ok=1", f.b, f.ok, e);
      end
    end
  endtask

  task automatic test_data_stability();
    logic [7:0] vals[2];
    bit         ok;
    int         acc;
    frame_t     f;
    logic [7:0] e;
    vals[0] = 8'h96;
    vals[1] = 8'h0F;
    for (int v = 0; v < 2; v++) begin
      accept_byte(vals[v], 1, ok, acc);
      for (int i = 0; i < FRAME - 4; i++) begin
        data = 8'($urandom);
        @(negedge clk);
      end
      wait_obs(1, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL stable_timeout: no frame decoded for byte %0d, required 1", v);
      end else begin
        f = obs_q.pop_front();
        e = exp_q.pop_front();
        if (f.b !== e || !f.ok) begin
          n_fail++;
          $display("FAIL stable_decode: got 0x%02h ok=%0b, required 0x%02h ok=1", f.b, f.ok, e);
        end
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single_frame();
    test_en_held();
    test_back_to_back();
    test_reset_mid_frame();
    test_data_stability();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_unit.md
Name:
uart_tx_unit

Overview:
Byte-wide UART transmitter: accepts one byte through a ready/enable handshake and serializes it on a single line as 8N1. The frame is one start bit (0), eight data bits LSB first, and one stop bit (1). It sits between a byte producer, such as a character generator or FIFO, and the physical TX pin. Bit timing is derived from the system clock by an integer divider.

Parameters:
CLKS_PER_BIT, 868, system clock cycles per bit; 100 MHz / 115200 baud; must be >= 2.

Ports:
clk  input  1  system clock; all state is updated on the rising edge.
rst  input  1  asynchronous, active-low reset; 0 forces the idle state immediately.
en  input  1  transmit request; sampled on rising clk, acted on only when rdy=1.
data  input  8  byte to send; captured on the accepting edge.
rdy  output  1  1 = idle and able to accept a byte.
tx  output  1  serial line; idles high.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, rdy=1, state=IDLE.
  - Bit counter and baud counter cleared.
  - A frame in progress is aborted with no partial stop bit.
- States are IDLE, START, DATA and STOP.
- IDLE:
  - rdy=1, tx=1.
  - On a rising edge with en=1, the byte is accepted: data is latched into the shift register, the state moves to START, rdy goes 0 and tx goes 0, all registered on that same edge.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - tx = latched[index] for CLKS_PER_BIT cycles per bit, index 0..7 (LSB first).
  - After bit 7 the state moves to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - Then IDLE with rdy=1, registered on the edge that ends the stop bit.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the accepting edge to rdy rising.
- en while rdy=0 is ignored; no queuing and no error flag.
- A producer holding en=1 for one extra cycle after acceptance must not start a second frame.
- data changes after acceptance do not affect the frame in flight.
- Back-to-back frames:
  - en=1 on the first edge where rdy=1 starts the next start bit immediately.
  - The minimum idle gap is one clock cycle of tx=1 after the stop bit.
- Baud counter counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is cleared on acceptance.
  - Its width is clog2(CLKS_PER_BIT).
- All outputs are registered; tx has no combinational path from inputs.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP);
  - default CLKS_PER_BIT constant;
  - DATA_BITS=8 constant.
- One natural sub-module, uart_baud_tick:
  - parameterized counter with clear input;
  - outputs a one-cycle tick at bit end.
- The FSM and shift register stay in uart_tx_unit.

Test Plan:
1. Reset and idle. Hold rst=0 for 20 cycles, then release. Required: tx=1 and rdy=1 throughout reset and afterwards while en=0.
2. Single frame with CLKS_PER_BIT=16. Accept data=0x41. Required:
   - tx sequence 0,1,0,0,0,0,0,1,0,1, each level held 16 cycles;
   - rdy=0 for exactly 160 cycles after acceptance, then 1.
3. en held high for 2 cycles, as a producer that sets en on rdy. Accept 0x41, then drive data=0x42 with en=1 while rdy=0. Required:
   - exactly one 0x41 frame is sent;
   - 0x42 is sent only when en is reasserted after rdy returns.
4. Back-to-back cycling stream: producer sends 0x41..0x57 and wraps after 0x57 back to 0x41. Required:
   - decoded bytes are consecutive;
   - no frame is corrupted;
   - every stop bit is 1 for 16 cycles.
5. Reset mid-frame. Assert rst=0 during DATA bit 3. Required:
   - tx=1 and rdy=1 immediately, asynchronously;
   - after release the next frame is well-formed.
6. Data stability. Change data every cycle while busy. Required: the transmitted bits match the value latched at the accept edge.
